// File: rtl/switch_debounce.sv
// Slide-switch conditioner: per-bit synchroniser plus stability-counter debounce,
// with registered stable vector and one-cycle rise/fall/change strobes.
module switch_debounce #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] switch,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] rise_q, fall_q;
  logic             changed_q;

  // Plain flop chain; nothing may sit between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= switch;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mismatch;
    logic             at_max;

    assign mismatch    = sync_s[i] ^ stable_q[i];
    assign at_max      = (cnt_q == CntMax);
    // Any agreement with the stable value restarts the count from zero.
    assign cnt_d       = (mismatch && !at_max) ? cnt_q + CntOne : '0;
    assign stable_d[i] = (mismatch && at_max) ? sync_s[i] : stable_q[i];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q  <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      stable_q  <= stable_d;
      rise_q    <= stable_d & ~stable_q;
      fall_q    <= ~stable_d & stable_q;
      changed_q <= |(stable_d ^ stable_q);
    end
  end

  assign sw_stable  = stable_q;
  assign sw_rise    = rise_q;
  assign sw_fall    = fall_q;
  assign sw_changed = changed_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Directed checks of switch_debounce (D=4, S=2) plus a D=1, S=3 instance
// compared cycle by cycle against a behavioural model under random stimulus.
module tb_switch_debounce;

  localparam int unsigned D1 = 1;
  localparam int unsigned S1 = 3;

  logic       clk;
  logic       rst_n;
  logic [7:0] sw, stable, rise, fall;
  logic       chg;
  logic [7:0] sw1, stable1, rise1, fall1;
  logic       chg1;

  int checks = 0;
  int errors = 0;

  switch_debounce #(
    .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .switch(sw),
    .sw_stable(stable), .sw_rise(rise), .sw_fall(fall), .sw_changed(chg)
  );

  switch_debounce #(
    .WIDTH(8), .SYNC_STAGES(S1), .DEBOUNCE_CYCLES(D1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .switch(sw1),
    .sw_stable(stable1), .sw_rise(rise1), .sw_fall(fall1), .sw_changed(chg1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle just past the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_st, input logic [7:0] e_r,
                           input logic [7:0] e_f, input logic e_c);
    check(tag, {stable, rise, fall, 7'd0, chg}, {e_st, e_r, e_f, 7'd0, e_c});
  endtask

  // Reference model state for the D=1 instance.
  logic [7:0] m_sync [S1];
  logic [7:0] m_stable, m_rise, m_fall, m_nstable, m_s;
  logic       m_chg;
  int         m_cnt [8];

  initial begin
    rst_n = 1'b0;
    sw    = 8'hFF;
    sw1   = 8'h00;
    #1;
    check_all("reset_async", 8'h00, 8'h00, 8'h00, 1'b0);
    edges(3);
    check_all("reset_hold", 8'h00, 8'h00, 8'h00, 1'b0);

    // Power-up capture of switches already high.
    rst_n = 1'b1;
    edges(5);
    check_all("powerup_e5", 8'h00, 8'h00, 8'h00, 1'b0);
    edges(1);
    check_all("powerup_e6", 8'hFF, 8'hFF, 8'h00, 1'b1);
    edges(1);
    check_all("powerup_e7", 8'hFF, 8'h00, 8'h00, 1'b0);

    sw = 8'h00;
    edges(6);
    check_all("clear_all", 8'h00, 8'h00, 8'hFF, 1'b1);
    edges(1);

    // Clean step on bit 3.
    sw = 8'h08;
    edges(5);
    check_all("step_rise_e5", 8'h00, 8'h00, 8'h00, 1'b0);
    edges(1);
    check_all("step_rise_e6", 8'h08, 8'h08, 8'h00, 1'b1);
    edges(1);
    check_all("step_rise_e7", 8'h08, 8'h00, 8'h00, 1'b0);
    sw = 8'h00;
    edges(5);
    check_all("step_fall_e5", 8'h08, 8'h00, 8'h00, 1'b0);
    edges(1);
    check_all("step_fall_e6", 8'h00, 8'h00, 8'h08, 1'b1);
    edges(1);

    // Three-cycle glitch on bit 0 must be rejected.
    sw = 8'h01;
    edges(3);
    sw = 8'h00;
    for (int k = 0; k < 6; k++) begin
      edges(1);
      check_all("glitch_reject", 8'h00, 8'h00, 8'h00, 1'b0);
    end

    // Bounce 1,0 then held high: count runs from the last 0->1.
    sw = 8'h01;
    edges(1);
    sw = 8'h00;
    edges(1);
    sw = 8'h01;
    edges(5);
    check_all("bounce_e5", 8'h00, 8'h00, 8'h00, 1'b0);
    edges(1);
    check_all("bounce_e6", 8'h01, 8'h01, 8'h00, 1'b1);
    edges(1);
    sw = 8'h00;
    edges(7);
    check("bounce_clear", {24'd0, stable}, 32'h00);

    // Simultaneous multi-bit update.
    sw = 8'h0F;
    edges(7);
    check_all("simul_setup", 8'h0F, 8'h00, 8'h00, 1'b0);
    sw = 8'hF0;
    edges(5);
    check_all("simul_e5", 8'h0F, 8'h00, 8'h00, 1'b0);
    edges(1);
    check_all("simul_e6", 8'hF0, 8'hF0, 8'h0F, 1'b1);
    edges(1);
    check_all("simul_e7", 8'hF0, 8'h00, 8'h00, 1'b0);

    // Reset in the middle of a debounce on bit 5.
    sw = 8'h80;
    edges(7);
    check_all("midrst_setup", 8'h80, 8'h00, 8'h00, 1'b0);
    sw = 8'hA0;
    edges(3);
    rst_n = 1'b0;
    #1;
    check_all("midrst_async", 8'h00, 8'h00, 8'h00, 1'b0);
    edges(2);
    check_all("midrst_hold", 8'h00, 8'h00, 8'h00, 1'b0);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      edges(1);
      check_all("midrst_no_early", 8'h00, 8'h00, 8'h00, 1'b0);
    end
    edges(1);
    check_all("midrst_e6", 8'hA0, 8'hA0, 8'h00, 1'b1);
    edges(1);
    check_all("midrst_e7", 8'hA0, 8'h00, 8'h00, 1'b0);

    // D=1, S=3 instance: step appears after four edges.
    sw1 = 8'h01;
    edges(3);
    check("corner_e3", {16'd0, stable1, rise1}, 32'h0000);
    edges(1);
    check("corner_e4", {15'd0, stable1, rise1, chg1}, {15'd0, 8'h01, 8'h01, 1'b1});

    // Fresh reset, then random stimulus against the model.
    rst_n = 1'b0;
    sw1   = 8'h00;
    edges(2);
    rst_n = 1'b1;
    for (int k = 0; k < S1; k++) m_sync[k] = '0;
    for (int b = 0; b < 8; b++) m_cnt[b] = 0;
    m_stable = '0;
    for (int n = 0; n < 10000; n++) begin
      sw1 = 8'($urandom);
      m_s = m_sync[S1-1];
      m_nstable = m_stable;
      for (int b = 0; b < 8; b++) begin
        if (m_s[b] == m_stable[b]) begin
          m_cnt[b] = 0;
        end else if (m_cnt[b] == int'(D1) - 1) begin
          m_nstable[b] = m_s[b];
          m_cnt[b] = 0;
        end else begin
          m_cnt[b] = m_cnt[b] + 1;
        end
      end
      m_rise = m_nstable & ~m_stable;
      m_fall = ~m_nstable & m_stable;
      m_chg  = |(m_nstable ^ m_stable);
      m_stable = m_nstable;
      for (int k = S1 - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
      m_sync[0] = sw1;
      edges(1);
      check("random_d1", {7'd0, stable1, rise1, fall1, chg1},
            {7'd0, m_stable, m_rise, m_fall, m_chg});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
